// File: rtl/pwm_deadtime_gen.sv
// pwm_deadtime_gen: complementary half-bridge gate driver with dead time and fault latch; PWM_DEADTIME_STATS_EN enables swallow_cnt
module pwm_deadtime_gen #(
  parameter int DT_WIDTH  = 8,
  parameter int CNT_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 pwm_in,
  input  logic                 enable,
  input  logic [DT_WIDTH-1:0]  dead_time,
  input  logic                 fault,
  input  logic                 fault_clear,
  output logic                 gate_hi,
  output logic                 gate_lo,
  output logic                 fault_latched,
  output logic                 dt_active,
  output logic [CNT_WIDTH-1:0] swallow_cnt
);
  typedef enum logic [2:0] {IDLE, DT_TO_HI, HI_ON, DT_TO_LO, LO_ON, FAULT} state_t;
  state_t state, nxt;
  logic p_q;
  logic [DT_WIDTH-1:0] counter;
  logic [DT_WIDTH-1:0] dt_load;
  logic cnt_one, in_dt, load;
  assign dt_load = dead_time == '0 ? DT_WIDTH'(1) : dead_time;
  assign cnt_one = counter == DT_WIDTH'(1);
  // Next state: fault beats disable, disable beats normal sequencing; an edge back on pwm aborts dead time
  always_comb begin
    nxt = state;
    if (fault) nxt = FAULT;
    else if (state == FAULT) nxt = fault_clear ? IDLE : FAULT;
    else if (!enable) nxt = IDLE;
    else
      case (state)
        IDLE:     nxt = p_q ? DT_TO_HI : DT_TO_LO;
        LO_ON:    nxt = p_q ? DT_TO_HI : LO_ON;
        HI_ON:    nxt = p_q ? HI_ON : DT_TO_LO;
        DT_TO_HI: nxt = !p_q ? LO_ON : cnt_one ? HI_ON : DT_TO_HI;
        DT_TO_LO: nxt = p_q ? HI_ON : cnt_one ? LO_ON : DT_TO_LO;
        default:  nxt = IDLE;
      endcase
  end
  assign in_dt = nxt == DT_TO_HI || nxt == DT_TO_LO;
  assign load  = in_dt && nxt != state;
  // State, input sample, dead-time counter and outputs decoded from the next state so gates track state on the same edge
  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      p_q           <= 1'b0;
      counter       <= '0;
      gate_hi       <= 1'b0;
      gate_lo       <= 1'b0;
      fault_latched <= 1'b0;
      dt_active     <= 1'b0;
    end else begin
      state         <= nxt;
      p_q           <= pwm_in;
      counter       <= load ? dt_load : in_dt ? counter - DT_WIDTH'(1) : counter;
      gate_hi       <= nxt == HI_ON;
      gate_lo       <= nxt == LO_ON;
      fault_latched <= nxt == FAULT;
      dt_active     <= in_dt;
    end
  end
`ifdef PWM_DEADTIME_STATS_EN
  logic [CNT_WIDTH-1:0] sw;
  logic abort;
  assign abort = (state == DT_TO_HI && nxt == LO_ON) || (state == DT_TO_LO && nxt == HI_ON);
  // Saturating count of aborted dead intervals, cleared on reset and on leaving FAULT
  always_ff @(posedge clk) begin
    if (rst || (state == FAULT && nxt == IDLE)) sw <= '0;
    else if (abort && sw != '1) sw <= sw + CNT_WIDTH'(1);
  end
  assign swallow_cnt = sw;
`else
  assign swallow_cnt = '0;
`endif
endmodule
